// File: rtl/noc_vc_scheduler.sv
// Virtual-channel output-link scheduler: round-robin among head flits, then holds the link for the whole packet.
// Latency: the grant is combinational from the current state, so an ack can land in the same cycle as its grant.
// Backpressure: grant falls to zero while the granted VC's downstream is unavailable. NOC_VC_SCHEDULER_WATCHDOG_EN adds a stall watchdog.
module noc_vc_scheduler #(
  parameter int CHANNELS    = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic [CHANNELS-1:0] i_request,
  input  logic [CHANNELS-1:0] i_head,
  input  logic [CHANNELS-1:0] i_tail,
  input  logic [CHANNELS-1:0] i_vc_available,
  input  logic                i_ack,
  output logic [CHANNELS-1:0] o_grant,
  output logic                o_locked,
  output logic                o_stall_error
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         ptr, ptr_nxt;
  logic [PW-1:0]         lvc, lvc_nxt;
  logic [PW-1:0]         gidx;
  logic [CHANNELS-1:0]   eligible;
  logic [CHANNELS-1:0]   grant;
  logic [PW:0]           cand_sum;
  logic [PW-1:0]         cand;
  logic                  found;
  logic                  fire;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(CHANNELS - 1)) return '0;
    return v + PW'(1);
  endfunction

  // Only a packet head may start a new arbitration round.
  assign eligible = i_request & i_head & i_vc_available;

  always_comb begin
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    if (state == LOCKED) begin
      grant[lvc] = i_request[lvc] & i_vc_available[lvc];
      gidx       = lvc;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand_sum = {1'b0, ptr} + (PW+1)'(k);
        if (cand_sum >= (PW+1)'(CHANNELS)) cand_sum = cand_sum - (PW+1)'(CHANNELS);
        cand = cand_sum[PW-1:0];
        if (!found && eligible[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gidx        = cand;
        end
      end
    end
  end

  assign o_grant = grant;
  assign fire    = i_ack & (|grant);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lvc_nxt   = lvc;
    if (i_clear) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      lvc_nxt   = '0;
    end else if (fire) begin
      case (state)
        IDLE: begin
          if (i_tail[gidx]) begin
            ptr_nxt = wrap_inc(gidx);
          end else begin
            state_nxt = LOCKED;
            lvc_nxt   = gidx;
          end
        end
        LOCKED: begin
          // Body flits keep everything as is; only the tail releases the link.
          if (i_tail[lvc]) begin
            state_nxt = IDLE;
            ptr_nxt   = wrap_inc(lvc);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      lvc   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lvc   <= lvc_nxt;
    end
  end

  assign o_locked = (state == LOCKED);

`ifdef NOC_VC_SCHEDULER_WATCHDOG_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] stall_cnt, stall_cnt_nxt;
  logic          stall_err;

  // Counts consecutive un-acked cycles while a packet holds the link; saturates at the limit.
  always_comb begin
    stall_cnt_nxt = '0;
    if (state == LOCKED && !i_ack) begin
      stall_cnt_nxt = (stall_cnt == CW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (i_clear) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == CW'(STALL_LIMIT)) stall_err <= 1'b1;
    end
  end

  assign o_stall_error = stall_err;
`else
  assign o_stall_error = 1'b0;
`endif

`ifndef SYNTHESIS
  grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_grant));
`endif

endmodule

// File: tb/tb_noc_vc_scheduler.sv
// Directed-vector bench for noc_vc_scheduler (CHANNELS=4, STALL_LIMIT=8).
module tb_noc_vc_scheduler;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_clear = 1'b0;
  logic [CH-1:0] i_request = '0;
  logic [CH-1:0] i_head = '0;
  logic [CH-1:0] i_tail = '0;
  logic [CH-1:0] i_vc_available = '0;
  logic          i_ack = 1'b0;
  logic [CH-1:0] o_grant;
  logic          o_locked;
  logic          o_stall_error;

  int n_chk = 0;
  int n_err = 0;
  logic exp_stall;

  noc_vc_scheduler #(.CHANNELS(CH), .STALL_LIMIT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (i_clear),
    .i_request      (i_request),
    .i_head         (i_head),
    .i_tail         (i_tail),
    .i_vc_available (i_vc_available),
    .i_ack          (i_ack),
    .o_grant        (o_grant),
    .o_locked       (o_locked),
    .o_stall_error  (o_stall_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] req, input logic [CH-1:0] head,
                       input logic [CH-1:0] tail, input logic [CH-1:0] avail,
                       input logic ack);
    i_request      = req;
    i_head         = head;
    i_tail         = tail;
    i_vc_available = avail;
    i_ack          = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef NOC_VC_SCHEDULER_WATCHDOG_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    // Reset state
    #3;
    check("rst_locked", 32'(o_locked), 32'h0);
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_stall", 32'(o_stall_error), 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Single-flit round robin: 0,1,2,3,0
    drive(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", 32'(o_grant), 32'(1 << (i % 4)));
      tick();
    end
    drive('0, '0, '0, '0, 1'b0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;

    // VC1 3-flit packet while VC2 waits with a single-flit packet
    drive(4'b0110, 4'b0110, 4'b0100, 4'b1111, 1'b1);
    #1;
    check("pkt_head_grant", 32'(o_grant), 32'h2);
    check("pkt_head_locked", 32'(o_locked), 32'h0);
    tick();
    drive(4'b0110, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    #1;
    check("pkt_body_grant", 32'(o_grant), 32'h2);
    check("pkt_body_locked", 32'(o_locked), 32'h1);
    tick();
    drive(4'b0110, 4'b0100, 4'b0110, 4'b1111, 1'b1);
    #1;
    check("pkt_tail_grant", 32'(o_grant), 32'h2);
    check("pkt_tail_locked", 32'(o_locked), 32'h1);
    tick();
    drive(4'b0100, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    #1;
    check("pkt_next_grant", 32'(o_grant), 32'h4);
    check("pkt_next_locked", 32'(o_locked), 32'h0);
    tick();

    // ptr=3: search wraps past idle VC3 to VC1, then backpressure on VC1
    drive(4'b1010, 4'b0010, 4'b0000, 4'b1111, 1'b1);
    #1;
    check("bp_lock_grant", 32'(o_grant), 32'h2);
    tick();
    drive(4'b1010, 4'b1000, 4'b0000, 4'b1101, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_grant", 32'(o_grant), 32'h0);
      check("bp_locked", 32'(o_locked), 32'h1);
      tick();
    end
    drive(4'b1010, 4'b1000, 4'b0010, 4'b1111, 1'b1);
    #1;
    check("bp_resume_grant", 32'(o_grant), 32'h2);
    tick();

    // Move ptr to 3, then wrap from VC3 to VC0
    drive(4'b0100, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    #1;
    check("wrap_setup_grant", 32'(o_grant), 32'h4);
    tick();
    drive(4'b1001, 4'b1001, 4'b1001, 4'b1111, 1'b1);
    #1;
    check("wrap_vc3_grant", 32'(o_grant), 32'h8);
    tick();
    #1;
    check("wrap_vc0_grant", 32'(o_grant), 32'h1);
    tick();

    // Asynchronous reset while LOCKED on VC2
    drive(4'b0100, 4'b0100, 4'b0000, 4'b1111, 1'b1);
    #1;
    check("mid_lock_grant", 32'(o_grant), 32'h4);
    tick();
    drive(4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    #1;
    check("mid_locked", 32'(o_locked), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_locked", 32'(o_locked), 32'h0);
    #1 rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0);
    #1;
    check("mid_rst_grant", 32'(o_grant), 32'h1);
    tick();

    // Stalled packet on VC1: watchdog trips after 8 un-acked LOCKED cycles
    drive(4'b0010, 4'b0010, 4'b0000, 4'b1111, 1'b1);
    #1;
    check("wd_lock_grant", 32'(o_grant), 32'h2);
    tick();
    drive(4'b0010, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    repeat (7) tick();
    #1;
    check("wd_before_limit", 32'(o_stall_error), 32'h0);
    tick();
    #1;
    check("wd_at_limit", 32'(o_stall_error), 32'(exp_stall));
    i_ack = 1'b1;
    tick();
    #1;
    check("wd_sticky", 32'(o_stall_error), 32'(exp_stall));
    check("wd_still_locked", 32'(o_locked), 32'h1);

    // Clear and ack together: clear wins, ptr returns to 0
    i_clear = 1'b1;
    #1;
    check("clr_grant", 32'(o_grant), 32'h2);
    tick();
    i_clear = 1'b0;
    drive(4'b1010, 4'b1010, 4'b1010, 4'b1111, 1'b0);
    #1;
    check("clr_locked", 32'(o_locked), 32'h0);
    check("clr_stall", 32'(o_stall_error), 32'h0);
    check("clr_ptr_grant", 32'(o_grant), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/noc_vc_scheduler.md
NOC_VC_SCHEDULER -- requirements
Module: noc_vc_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of virtual channels sharing one output link (2..16).
REQ-002 SHALL have parameter STALL_LIMIT, default 255: watchdog cycle limit (used only under REQ-030).
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_clear, input, 1: synchronous return to the reset state.
REQ-006 SHALL have port i_request, input, CHANNELS: per-VC FIFO head valid (FIFO not empty).
REQ-007 SHALL have port i_head, input, CHANNELS: per-VC head flit is a packet head flit.
REQ-008 SHALL have port i_tail, input, CHANNELS: per-VC head flit is a packet tail flit.
REQ-009 SHALL have port i_vc_available, input, CHANNELS: downstream VC can accept (almost-full inverted).
REQ-010 SHALL have port i_ack, input, 1: output link accepted the granted flit this cycle (valid&ready).
REQ-011 SHALL have port o_grant, output, CHANNELS: one-hot or zero grant, which selects the FIFO to pop.
REQ-012 SHALL have port o_locked, output, 1: a multi-flit packet holds the link.
REQ-013 SHALL have port o_stall_error, output, 1: watchdog flag (REQ-030).

Function
REQ-014 SHALL keep state IDLE or LOCKED, plus a round-robin pointer ptr (log2 CHANNELS bits) and a lock index lvc.
REQ-015 In IDLE, SHALL define eligible[i] = i_request[i] & i_head[i] & i_vc_available[i].
REQ-016 In IDLE, SHALL drive o_grant combinationally to the first eligible channel found by searching from ptr upward, wrapping at CHANNELS-1 to 0.
REQ-017 In IDLE, SHALL drive o_grant to zero when no channel is eligible.
REQ-018 In LOCKED, SHALL drive o_grant[lvc] = i_request[lvc] & i_vc_available[lvc], with all other bits zero.
REQ-019 In LOCKED, SHALL give no other VC any grant, regardless of its requests.
REQ-020 On i_ack with granted channel g in IDLE and i_tail[g]=0, SHALL move to LOCKED with lvc=g in the next cycle.
REQ-021 On i_ack in IDLE with i_tail[g]=1 (single-flit packet), SHALL stay IDLE and set ptr=(g+1) mod CHANNELS.
REQ-022 On i_ack in LOCKED with i_tail[lvc]=1, SHALL return to IDLE and set ptr=(lvc+1) mod CHANNELS.
REQ-023 On i_ack in LOCKED with i_tail[lvc]=0, SHALL hold state, lvc and ptr.
REQ-024 SHALL ignore i_ack while o_grant is zero, with no state change.
REQ-025 SHALL drive o_locked = (state==LOCKED) as a registered value.
REQ-026 Grant-to-ack latency: SHALL be zero cycles, so one flit can transfer per cycle, back-to-back within a packet and across packets.
REQ-027 If i_clear and i_ack are both high in the same cycle, i_clear SHALL win.
REQ-028 Grants SHALL always be one-hot or zero.

Reset
REQ-029 On rst_n low, asynchronously and also on i_clear, SHALL set state=IDLE, ptr=0, lvc=0 and watchdog count=0, with o_locked=0, o_stall_error=0, and o_grant following REQ-016/017 from ptr=0.

Configuration
REQ-030 With NOC_VC_SCHEDULER_WATCHDOG_EN defined, SHALL count consecutive LOCKED cycles without i_ack (saturating, cleared on i_ack or IDLE) and set sticky o_stall_error when the count reaches STALL_LIMIT.
REQ-031 The o_stall_error flag SHALL clear only by reset or i_clear.
REQ-032 Without NOC_VC_SCHEDULER_WATCHDOG_EN, SHALL tie o_stall_error to 0 and synthesize no counter.

Verification
REQ-033 Single-flit round-robin: CHANNELS=4, all VCs request head+tail flits, i_ack every cycle -> grants 0,1,2,3,0 in consecutive cycles.
REQ-034 Packet lock: VC1 sends a 3-flit packet (head, body, tail) while VC2 requests -> o_grant=0010 for 3 acks, o_locked=1 during cycles 2-3, then o_grant=0100 (VC2).
REQ-035 Backpressure: in LOCKED on VC1, drop i_vc_available[1] for 5 cycles -> o_grant=0000, VC3 is not granted, and state is held.
REQ-036 Wrap: ptr=3, only VC0 and VC3 eligible -> grant VC3; after a tail ack, grant VC0.
REQ-037 Reset mid-packet: rst_n pulsed low while LOCKED on VC2 -> o_locked=0, ptr=0, and VC0 is granted first.
REQ-038 Watchdog (macro on, STALL_LIMIT=8): LOCKED, no i_ack for 8 cycles -> o_stall_error=1 and stays high until i_clear.
